lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
- Parametrised LIFO stack, successor to the fixed 32x8 stack.
- Generalised data width and depth; single clock, registered pop data with valid strobe.
- Adds simultaneous push/pop (replace-top), occupancy count, sticky overflow/underflow error flags and synchronous flush.
- Sits between a producer/consumer datapath and internal inferred storage; no external RAM module.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 32, number of entries (>=2, need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of count/stack pointer (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low.
- en  input  1  operation enable; push/pop/clear ignored when 0.
- push  input  1  push request.
- pop  input  1  pop request.
- clear  input  1  synchronous flush; empties stack.
- err_clr  input  1  synchronous clear of overflow/underflow.
- din  input  DATA_W  push data.
- dout  output  DATA_W  popped data, registered.
- dout_valid  output  1  one-cycle strobe: dout updated this cycle.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  CNT_W  current occupancy.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst=0, async): sp=0, dout=0, dout_valid=0, overflow=0, underflow=0. Storage not reset (contents undefined).
- State: stack pointer sp in 0..DEPTH = count. Next write slot = mem[sp]; top = mem[sp-1].
- empty/full/count: combinational from sp, no latency.
- All ops sampled at rising clk only when en=1; en=0: no state change, dout_valid=0 next cycle.
- Priority per cycle: clear > (push/pop decode). err_clr independent.
- clear=1: sp<=0, dout_valid<=0, dout holds; push/pop that cycle ignored, no error flagged.
- push only, not full: mem[sp]<=din, sp<=sp+1.
- push only, full: no write, sp holds, overflow<=1.
- pop only, not empty: dout<=mem[sp-1], dout_valid<=1, sp<=sp-1. Latency 1 cycle from pop edge to dout/dout_valid.
- pop only, empty: dout holds, dout_valid<=0, underflow<=1.
- push+pop, not empty (incl. full): dout<=old mem[sp-1], mem[sp-1]<=din, sp unchanged, dout_valid<=1, no overflow.
- push+pop, empty: pass-through: dout<=din, dout_valid<=1, sp stays 0, no underflow.
- dout_valid deasserts the cycle after any cycle without a successful pop.
- err_clr=1: overflow<=0, underflow<=0; if an error event occurs same cycle, the flag is set (set wins).
- Back-to-back pops drain one entry per cycle; pop reaching sp=0 asserts empty the next cycle.
- Async reset mid-operation: immediate return to reset state; in-flight push discarded.

Optional Feature:
- Macro: LIFO_STACK_WATERMARK_EN.
- Defined: adds parameters AF_LVL (default DEPTH-2) and AE_LVL (default 2) plus outputs almost_full (count>=AF_LVL) and almost_empty (count<=AE_LVL), combinational from sp; both 0/1 per reset value of sp (almost_full=0, almost_empty=1).
- Undefined: parameters and ports absent; behaviour otherwise identical.

Test Plan:
- Reset then push 0x11,0x22,0x33 (DEPTH=32) -> count=3, empty=0; three pops return 0x33,0x22,0x11 each 1 cycle after pop with dout_valid=1, then empty=1.
- Push 32 values 0x00..0x1F -> full=1 at count=32; 33rd push 0xAA -> count stays 32, overflow=1; pop returns 0x1F.
- Pop on empty -> underflow=1, dout_valid=0, dout holds last value; err_clr pulse -> underflow=0; err_clr with simultaneous empty pop -> underflow stays 1.
- Stack holds 0x01,0x02; push+pop with din=0x55 -> dout=0x02, count=2; next pop -> 0x55. Empty push+pop din=0x77 -> dout=0x77, dout_valid=1, count=0.
- count=5, assert clear with push=1 -> count=0, empty=1, no overflow; en=0 with push=1 -> count unchanged.
- Assert rst=0 mid-burst between clock edges -> count=0, dout=0, flags 0 immediately; with LIFO_STACK_WATERMARK_EN, count=30 -> almost_full=1, count=2 -> almost_empty=1.

Source files
------------

// File: rtl/lifo_stack_if.sv
// lifo_stack_if
//   Bundles the LIFO stack's control, data and status signals.
//   Parameters: DATA_W (word width), DEPTH (entries). CNT_W is derived.
//   master modport: producer/consumer side (drives en/push/pop/clear/err_clr/din).
//   slave modport : the stack itself (drives dout/dout_valid/empty/full/count/
//                   overflow/underflow, and almost_full/almost_empty when
//                   LIFO_STACK_WATERMARK_EN is defined).
interface lifo_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              en;
  logic              push;
  logic              pop;
  logic              clear;
  logic              err_clr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
`ifdef LIFO_STACK_WATERMARK_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  modport master (
`ifdef LIFO_STACK_WATERMARK_EN
    input  almost_full, almost_empty,
`endif
    output en, push, pop, clear, err_clr, din,
    input  dout, dout_valid, empty, full, count, overflow, underflow
  );

  modport slave (
`ifdef LIFO_STACK_WATERMARK_EN
    output almost_full, almost_empty,
`endif
    input  en, push, pop, clear, err_clr, din,
    output dout, dout_valid, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack
//   Parametrised LIFO stack with registered pop data and a one-cycle valid
//   strobe. Supports simultaneous push/pop (replace top, or pass-through when
//   empty), occupancy count, sticky overflow/underflow flags and a synchronous
//   flush. Storage is inferred and not reset.
//   Optional: define LIFO_STACK_WATERMARK_EN to add AF_LVL/AE_LVL parameters
//   and the almost_full/almost_empty outputs.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - lifo_stack_if.slave (en, push, pop, clear, err_clr, din in;
//          dout, dout_valid, empty, full, count, overflow, underflow out)
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
`ifdef LIFO_STACK_WATERMARK_EN
  ,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
`endif
) (
  input  logic         clk,
  input  logic         rst,
  lifo_stack_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              ovf_p1;
  logic              udf_p1;

  logic              is_empty;
  logic              is_full;
  logic              act;
  logic              push_only;
  logic              pop_only;
  logic              ovf_evt;
  logic              udf_evt;
  logic              swap;
  logic              pass;
  logic              wr_en;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_idx;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CNT_W'(DEPTH));

  // clear pre-empts push/pop decode; nothing else happens in a flush cycle
  assign act       = bus.en & ~bus.clear;
  assign push_only = act &  bus.push & ~bus.pop & ~is_full;
  assign ovf_evt   = act &  bus.push & ~bus.pop &  is_full;
  assign pop_only  = act & ~bus.push &  bus.pop & ~is_empty;
  assign udf_evt   = act & ~bus.push &  bus.pop &  is_empty;
  assign swap      = act &  bus.push &  bus.pop & ~is_empty;
  assign pass      = act &  bus.push &  bus.pop &  is_empty;

  // top_idx wraps when sp==0, but it is only used when the stack is non-empty
  assign top_idx = AW'(sp - CNT_W'(1));
  assign wr_idx  = swap ? top_idx : AW'(sp);
  // a write coinciding with an active reset is dropped so a reset edge
  // discards any in-flight push
  assign wr_en   = rst & (push_only | swap);

  // Storage write (no reset on storage)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.din;
    end
  end

  // Pointer, registered pop data and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      ovf_p1  <= 1'b0;
      udf_p1  <= 1'b0;
    end else begin
      vld_p1 <= pop_only | swap | pass;

      // swap reads the old top in the same edge that overwrites it
      if (pop_only | swap) begin
        dout_p1 <= mem[top_idx];
      end else if (pass) begin
        dout_p1 <= bus.din;
      end

      if (bus.en & bus.clear) begin
        sp <= '0;
      end else if (push_only) begin
        sp <= sp + CNT_W'(1);
      end else if (pop_only) begin
        sp <= sp - CNT_W'(1);
      end

      // a same-cycle error event beats err_clr
      if (ovf_evt) begin
        ovf_p1 <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_p1 <= 1'b0;
      end

      if (udf_evt) begin
        udf_p1 <= 1'b1;
      end else if (bus.err_clr) begin
        udf_p1 <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = sp;
  assign bus.overflow   = ovf_p1;
  assign bus.underflow  = udf_p1;

`ifdef LIFO_STACK_WATERMARK_EN
  assign bus.almost_full  = (sp >= CNT_W'(AF_LVL));
  assign bus.almost_empty = (sp <= CNT_W'(AE_LVL));
`endif
endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lifo_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue whose back is the top of stack
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_vld  = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_udf  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      bit ov;
      bit ud;
      ov = 1'b0;
      ud = 1'b0;
      m_vld = 1'b0;
      if (bus.en) begin
        if (bus.clear) begin
          q.delete();
        end else if (bus.push && bus.pop) begin
          if (q.size() == 0) begin
            m_dout = bus.din;
          end else begin
            m_dout = q[q.size()-1];
            q[q.size()-1] = bus.din;
          end
          m_vld = 1'b1;
        end else if (bus.push) begin
          if (q.size() == DEPTH) ov = 1'b1;
          else q.push_back(bus.din);
        end else if (bus.pop) begin
          if (q.size() == 0) ud = 1'b1;
          else begin
            m_dout = q.pop_back();
            m_vld  = 1'b1;
          end
        end
      end
      if (ov) m_ovf = 1'b1; else if (bus.err_clr) m_ovf = 1'b0;
      if (ud) m_udf = 1'b1; else if (bus.err_clr) m_udf = 1'b0;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("m_count", 32'(bus.count), 32'(q.size()));
    chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("m_full",  32'(bus.full),  32'(q.size() == DEPTH));
    chk("m_dout",  32'(bus.dout),  32'(m_dout));
    chk("m_vld",   32'(bus.dout_valid), 32'(m_vld));
    chk("m_ovf",   32'(bus.overflow),   32'(m_ovf));
    chk("m_udf",   32'(bus.underflow),  32'(m_udf));
  end

  // One clocked operation; controls return to idle right after the edge
  task automatic op(input logic e, input logic pu, input logic po,
                    input logic cl, input logic ec, input logic [DATA_W-1:0] d);
    bus.en = e; bus.push = pu; bus.pop = po; bus.clear = cl;
    bus.err_clr = ec; bus.din = d;
    @(posedge clk);
    #1;
    bus.en = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic push_v(input logic [DATA_W-1:0] d); op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d); endtask
  task automatic pop_v();  op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
    bus.err_clr = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dout",  32'(bus.dout),  32'd0);
    chk("rst_vld",   32'(bus.dout_valid), 32'd0);
`ifdef LIFO_STACK_WATERMARK_EN
    chk("rst_af", 32'(bus.almost_full),  32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // basic LIFO ordering
    push_v(8'h11); push_v(8'h22); push_v(8'h33);
    chk("p3_count", 32'(bus.count), 32'd3);
    chk("p3_empty", 32'(bus.empty), 32'd0);
    pop_v();
    chk("pop1_dout", 32'(bus.dout), 32'h33);
    chk("pop1_vld",  32'(bus.dout_valid), 32'd1);
    pop_v();
    chk("pop2_dout", 32'(bus.dout), 32'h22);
    pop_v();
    chk("pop3_dout", 32'(bus.dout), 32'h11);
    chk("pop3_empty", 32'(bus.empty), 32'd1);
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("idle_vld", 32'(bus.dout_valid), 32'd0);

    // fill to full, overflow
    for (int i = 0; i < DEPTH; i++) push_v(8'(i));
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_count", 32'(bus.count), 32'd32);
`ifdef LIFO_STACK_WATERMARK_EN
    chk("full_af", 32'(bus.almost_full), 32'd1);
`endif
    push_v(8'hAA);
    chk("ovf_count", 32'(bus.count), 32'd32);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    pop_v();
    chk("ovf_pop", 32'(bus.dout), 32'h1F);
`ifdef LIFO_STACK_WATERMARK_EN
    pop_v();
    chk("c30_af", 32'(bus.almost_full), 32'd1);
    pop_v();
    chk("c29_af", 32'(bus.almost_full), 32'd0);
`endif
    op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("errclr_ovf", 32'(bus.overflow), 32'd0);

    // underflow and err_clr
    pop_v();
    chk("udf_flag", 32'(bus.underflow), 32'd1);
    chk("udf_vld",  32'(bus.dout_valid), 32'd0);
`ifdef LIFO_STACK_WATERMARK_EN
    chk("udf_dout", 32'(bus.dout), 32'h1D);
`else
    chk("udf_dout", 32'(bus.dout), 32'h1F);
`endif
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_clr", 32'(bus.underflow), 32'd0);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("udf_setwins", 32'(bus.underflow), 32'd1);
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // replace-top and pass-through
    push_v(8'h01); push_v(8'h02);
    op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    chk("swap_dout",  32'(bus.dout), 32'h02);
    chk("swap_count", 32'(bus.count), 32'd2);
    chk("swap_vld",   32'(bus.dout_valid), 32'd1);
    pop_v();
    chk("swap_pop", 32'(bus.dout), 32'h55);
    pop_v();
    chk("swap_pop2", 32'(bus.dout), 32'h01);
    op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    chk("pass_dout",  32'(bus.dout), 32'h77);
    chk("pass_vld",   32'(bus.dout_valid), 32'd1);
    chk("pass_count", 32'(bus.count), 32'd0);
    chk("pass_udf",   32'(bus.underflow), 32'd0);

    // clear beats push; en gating
    for (int i = 0; i < 5; i++) push_v(8'(8'hA0 + i));
    chk("c5_count", 32'(bus.count), 32'd5);
    op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    chk("clrp_count", 32'(bus.count), 32'd0);
    chk("clrp_empty", 32'(bus.empty), 32'd1);
    chk("clrp_ovf",   32'(bus.overflow), 32'd0);
    push_v(8'h3C);
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    chk("en0_count", 32'(bus.count), 32'd1);
    pop_v();
    chk("en0_pop", 32'(bus.dout), 32'h3C);

`ifdef LIFO_STACK_WATERMARK_EN
    push_v(8'h01); push_v(8'h02);
    chk("c2_ae", 32'(bus.almost_empty), 32'd1);
    push_v(8'h03);
    chk("c3_ae", 32'(bus.almost_empty), 32'd0);
    op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`endif

    // async reset mid-operation
    pop_v();
    push_v(8'h41); push_v(8'h42); push_v(8'h43);
    pop_v();
    chk("pre_rst_dout", 32'(bus.dout), 32'h43);
    bus.en = 1'b1; bus.push = 1'b1; bus.din = 8'h5A;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_dout",  32'(bus.dout),  32'd0);
    chk("arst_vld",   32'(bus.dout_valid), 32'd0);
    chk("arst_udf",   32'(bus.underflow), 32'd0);
    chk("arst_ovf",   32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    chk("arst_hold", 32'(bus.count), 32'd0);
    bus.en = 1'b0; bus.push = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    push_v(8'h66);
    pop_v();
    chk("post_rst_pop", 32'(bus.dout), 32'h66);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
